jkbank_arb_ctl: RTL and testbench

//  Round-robin arbiter/sequencer sharing one N-bit JK flip-flop register bank among NREQ requesters.

---
 rtl/jkbank_arb_ctl.sv | 145 ++++++++++++++
 tb/tb_jkbank_arb_ctl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/jkbank_arb_ctl.sv
// jkbank_arb_ctl: round-robin sequencer that turns SET/CLR/TOG/LOAD requests into J/K vectors
// for a shared JK register bank and returns the post-update bank contents to the winner.
module jkbank_arb_ctl #(
  parameter int N          = 8,
  parameter int NREQ       = 4,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                CLK,
  input  logic                RSTB,
  input  logic [NREQ-1:0]     REQ,
  input  logic [2*NREQ-1:0]   OP,
  input  logic [N*NREQ-1:0]   MASK,
  input  logic [N*NREQ-1:0]   WDATA,
  input  logic [N-1:0]        Q,
  output logic [N-1:0]        J,
  output logic [N-1:0]        K,
  output logic [NREQ-1:0]     GNT,
  output logic [NREQ-1:0]     DONE,
  output logic [N-1:0]        RDATA,
  output logic                BUSY
);

  // state    | meaning
  // S_INIT   | reset landing; arms the one-cycle bank clear
  // S_CLEAR  | K all-ones presented to the bank
  // S_IDLE   | J=K=0, arbitrate eligible requests
  // S_ISSUE  | winner's J/K presented, bank captures at closing edge
  // S_SETTLE | bank updated; Q captured into RDATA at closing edge

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {S_INIT, S_CLEAR, S_IDLE, S_ISSUE, S_SETTLE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt, win_idx;
  logic [NREQ-1:0] own, own_nxt, elig, win_oh, gnt_nxt, done_nxt;
  logic            win_found, busy_nxt;
  logic [1:0]      op_w;
  logic [N-1:0]    m_w, d_w, j_nxt, k_nxt, rdata_nxt;

  // a requester is blind to arbitration in its own DONE cycle so it can drop REQ cleanly
  assign elig = REQ & ~DONE;

  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    for (int i = 1; i <= NREQ; i++) begin
      if (!win_found && elig[PW'((int'(ptr) + i) % NREQ)]) begin
        win_found = 1'b1;
        win_idx   = PW'((int'(ptr) + i) % NREQ);
      end
    end
  end

  assign win_oh = NREQ'(1) << win_idx;

  always_comb begin
    op_w = '0;
    m_w  = '0;
    d_w  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == PW'(i)) begin
        op_w = OP[2*i +: 2];
        m_w  = MASK[N*i +: N];
        d_w  = WDATA[N*i +: N];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    own_nxt   = own;
    j_nxt     = '0;
    k_nxt     = '0;
    gnt_nxt   = '0;
    done_nxt  = '0;
    busy_nxt  = 1'b0;
    rdata_nxt = RDATA;
    case (state)
      S_INIT: begin
        k_nxt     = '1;
        busy_nxt  = 1'b1;
        state_nxt = S_CLEAR;
      end
      S_CLEAR: state_nxt = S_IDLE;
      S_IDLE: begin
        if (win_found) begin
          state_nxt = S_ISSUE;
          busy_nxt  = 1'b1;
          gnt_nxt   = win_oh;
          own_nxt   = win_oh;
          ptr_nxt   = win_idx;
          case (op_w)
            2'b00: j_nxt = m_w;
            2'b01: k_nxt = m_w;
            2'b10: begin
              j_nxt = m_w;
              k_nxt = m_w;
            end
            default: begin
              j_nxt = d_w & m_w;
              k_nxt = ~d_w & m_w;
            end
          endcase
        end
      end
      S_ISSUE: begin
        busy_nxt  = 1'b1;
        state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        done_nxt  = own;
        rdata_nxt = Q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      state <= INIT_CLEAR ? S_INIT : S_IDLE;
      ptr   <= PW'(NREQ - 1);
      own   <= '0;
      J     <= '0;
      K     <= '0;
      GNT   <= '0;
      DONE  <= '0;
      RDATA <= '0;
      BUSY  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      own   <= own_nxt;
      J     <= j_nxt;
      K     <= k_nxt;
      GNT   <= gnt_nxt;
      DONE  <= done_nxt;
      RDATA <= rdata_nxt;
      BUSY  <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_jkbank_arb_ctl.sv
// Bench for jkbank_arb_ctl: behavioural JK bank, expected-op scoreboard, vector table plus
// hand-written sequences for init clear, reset abort and round-robin under full load.
module tb_jkbank_arb_ctl;
  localparam int N    = 8;
  localparam int NREQ = 4;

  logic              CLK = 1'b0;
  logic              RSTB;
  logic [NREQ-1:0]   REQ;
  logic [2*NREQ-1:0] OP;
  logic [N*NREQ-1:0] MASK, WDATA;
  logic [N-1:0]      bank = 8'hA5;
  logic [N-1:0]      J, K, RDATA;
  logic [NREQ-1:0]   GNT, DONE;
  logic              BUSY;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic [N-1:0]    j;
    logic [N-1:0]    k;
    logic [N-1:0]    rd;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int         r;
    logic [1:0] op;
    logic [7:0] m, d, j, k, rd;
  } vec_t;
  vec_t vt[6];

  jkbank_arb_ctl #(.N(N), .NREQ(NREQ), .INIT_CLEAR(1'b1)) dut (
    .CLK(CLK), .RSTB(RSTB), .REQ(REQ), .OP(OP), .MASK(MASK), .WDATA(WDATA), .Q(bank),
    .J(J), .K(K), .GNT(GNT), .DONE(DONE), .RDATA(RDATA), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // JK bank with no reset: set, clear, toggle or hold per bit
  always @(posedge CLK) bank <= (J & ~bank) | (~K & bank);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input logic [7:0] m, input logic [7:0] d);
    OP[2*r +: 2]    = op;
    MASK[N*r +: N]  = m;
    WDATA[N*r +: N] = d;
    REQ[r]          = 1'b1;
  endtask

  task automatic push(input logic [3:0] g, input logic [7:0] j, input logic [7:0] k, input logic [7:0] rd);
    exp_t e;
    e.gnt = g; e.j = j; e.k = k; e.rd = rd;
    sb.push_back(e);
  endtask

  // scoreboard side: grant J/K and DONE/RDATA checked against the oldest pending op
  always @(negedge CLK) begin
    if (RSTB) begin
      if (GNT != '0) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_gnt: got GNT=%b with no op pending (cycle %0d)", GNT, cyc);
        end else begin
          chk("gnt", 32'(GNT), 32'(sb[0].gnt));
          chk("j_issue", 32'(J), 32'(sb[0].j));
          chk("k_issue", 32'(K), 32'(sb[0].k));
        end
      end else begin
        chk("jk_exclusive", 32'(J != '0 && K != '0), 32'(0));
      end
      if (DONE != '0) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got DONE=%b with no op pending (cycle %0d)", DONE, cyc);
        end else begin
          chk("done", 32'(DONE), 32'(sb[0].gnt));
          chk("rdata", 32'(RDATA), 32'(sb[0].rd));
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kff, nbusy, tg, td, seen;
    logic [3:0] drop, gfirst;
    bit again;

    vt[0] = '{0, 2'b00, 8'h0F, 8'h00, 8'h0F, 8'h00, 8'h0F};
    vt[1] = '{0, 2'b10, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hF0};
    vt[2] = '{1, 2'b00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
    vt[3] = '{2, 2'b11, 8'hF0, 8'h3C, 8'h30, 8'hC0, 8'h3F};
    vt[4] = '{3, 2'b01, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h30};
    vt[5] = '{1, 2'b00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h30};

    // reset and init clear of a bank preloaded with A5
    RSTB = 1'b0; REQ = '0; OP = '0; MASK = '0; WDATA = '0;
    repeat (3) tick();
    chk("rst_j", 32'(J), 0);
    chk("rst_k", 32'(K), 0);
    chk("rst_gnt", 32'(GNT), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_rdata", 32'(RDATA), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_bank_hold", 32'(bank), 32'h A5);
    RSTB = 1'b1;
    kff = 0; nbusy = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (K == 8'hFF) kff++;
      if (BUSY) nbusy++;
    end
    chk("init_k_cycles", kff, 1);
    chk("init_busy_cycles", nbusy, 1);
    chk("init_bank_cleared", 32'(bank), 0);

    // single-requester vectors; REQ is held through the DONE cycle, then dropped
    for (int v = 0; v < 6; v++) begin
      set_req(vt[v].r, vt[v].op, vt[v].m, vt[v].d);
      push(4'b0001 << vt[v].r, vt[v].j, vt[v].k, vt[v].rd);
      tg = -1; td = -1;
      for (int c = 0; c < 20 && td < 0; c++) begin
        tick();
        if (GNT != '0 && tg < 0) tg = cyc;
        if (DONE != '0) td = cyc;
      end
      if (td < 0 || tg < 0) begin
        checks++; errors++;
        $display("FAIL vec%0d_timeout: got no GNT/DONE within 20 cycles, required both", v);
      end else begin
        chk("latency", td - tg, 2);
      end
      tick();
      REQ[vt[v].r] = 1'b0;
      tick(); tick();
      chk("idle_busy", 32'(BUSY), 0);
      chk("idle_jk", 32'(J | K), 0);
    end

    // reset during SETTLE aborts the op; bank edge already taken stays
    set_req(1, 2'b01, 8'hF0, 8'h00);
    push(4'b0010, 8'h00, 8'hF0, 8'h00);
    for (int c = 0; c < 20; c++) begin
      tick();
      if (GNT != '0) break;
    end
    chk("abort_granted", 32'(GNT), 32'b0010);
    tick();
    chk("abort_settle_busy", 32'(BUSY), 1);
    RSTB = 1'b0;
    tick();
    chk("abort_done", 32'(DONE), 0);
    chk("abort_gnt", 32'(GNT), 0);
    chk("abort_jk", 32'(J | K), 0);
    chk("abort_busy", 32'(BUSY), 0);
    chk("abort_bank", 32'(bank), 0);
    sb.delete();
    REQ = '0;
    RSTB = 1'b1;
    set_req(0, 2'b00, 8'h0F, 8'h00);
    set_req(3, 2'b10, 8'hFF, 8'h00);
    push(4'b0001, 8'h0F, 8'h00, 8'h0F);
    push(4'b1000, 8'hFF, 8'hFF, 8'hF0);
    seen = 0; drop = '0; gfirst = '0;
    for (int c = 0; c < 40 && seen < 2; c++) begin
      tick();
      REQ = REQ & ~drop;
      drop = '0;
      if (gfirst == '0 && GNT != '0) gfirst = GNT;
      if (DONE != '0) begin seen++; drop = DONE; end
    end
    tick();
    REQ = REQ & ~drop;
    chk("rr_after_reset", 32'(gfirst), 32'b0001);
    chk("rr_after_reset_ops", seen, 2);

    // all four LOAD under continuous load; requester 0 re-requests with new data
    set_req(0, 2'b11, 8'h03, 8'h01);
    set_req(1, 2'b11, 8'h0C, 8'h08);
    set_req(2, 2'b11, 8'h30, 8'h20);
    set_req(3, 2'b11, 8'hC0, 8'hC0);
    push(4'b0001, 8'h01, 8'h02, 8'hF1);
    push(4'b0010, 8'h08, 8'h04, 8'hF9);
    push(4'b0100, 8'h20, 8'h10, 8'hE9);
    push(4'b1000, 8'hC0, 8'h00, 8'hE9);
    push(4'b0001, 8'h5A, 8'hA5, 8'h5A);
    seen = 0; drop = '0; again = 1'b0;
    for (int c = 0; c < 60 && seen < 5; c++) begin
      tick();
      REQ = REQ & ~drop;
      drop = '0;
      if (DONE != '0) begin
        seen++;
        if (DONE[0] && !again) begin
          again = 1'b1;
          MASK[7:0]  = 8'hFF;
          WDATA[7:0] = 8'h5A;
        end else begin
          drop = DONE;
        end
      end
    end
    tick();
    REQ = REQ & ~drop;
    chk("rr_load_ops", seen, 5);
    tick(); tick();
    chk("final_busy", 32'(BUSY), 0);
    chk("final_bank", 32'(bank), 32'h5A);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
